motor_sequenciador: RTL and testbench

- Controller for the two-cylinder 4-stroke engine model.
- Sequences the engine through stop, crank, run and shutdown phases, and ramps RPM toward a throttle-derived target.
- Advances both cylinders' one-hot stroke states at a rate proportional to RPM, using a phase accumulator.
- Issues per-cylinder ignition pulses, with a rev limiter.

---
 rtl/motor_sequenciador_if.sv | 43 ++++
 rtl/motor_sequenciador.sv | 177 +++++++++++++++++
 tb/tb_motor_sequenciador.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/motor_sequenciador_if.sv
// Bundle of the engine controller's command inputs and status outputs.
// master drives partida/desligar/acelerador; slave is the controller.
interface motor_sequenciador_if;
    logic        partida;
    logic        desligar;
    logic [7:0]  acelerador;
    logic [1:0]  estado_motor;
    logic        pronto;
    logic [3:0]  estado_cilindro1;
    logic [3:0]  estado_cilindro2;
    logic        ignicao1;
    logic        ignicao2;
    logic [12:0] rpm;
    logic [12:0] rpm_alvo;

    modport master (
        output partida,
        output desligar,
        output acelerador,
        input  estado_motor,
        input  pronto,
        input  estado_cilindro1,
        input  estado_cilindro2,
        input  ignicao1,
        input  ignicao2,
        input  rpm,
        input  rpm_alvo
    );

    modport slave (
        input  partida,
        input  desligar,
        input  acelerador,
        output estado_motor,
        output pronto,
        output estado_cilindro1,
        output estado_cilindro2,
        output ignicao1,
        output ignicao2,
        output rpm,
        output rpm_alvo
    );
endinterface

// File: rtl/motor_sequenciador.sv
// Two-cylinder 4-stroke engine controller: run-phase FSM, RPM ramp,
// phase-accumulator stroke sequencing and ignition with rev limiter.
// Ports: clk, reset (async, active low), bus (motor_sequenciador_if.slave).
module motor_sequenciador #(
    parameter int unsigned RPM_MAX          = 8000,
    parameter int unsigned RPM_PARTIDA      = 800,
    parameter int unsigned RPM_MARCHA_LENTA = 1000,
    parameter int unsigned GANHO_ACEL       = 28,
    parameter int unsigned RPM_LIMITE       = 7800,
    parameter int unsigned RAMPA_DIV        = 4,
    parameter int unsigned PASSO_FASE       = 20000
) (
    input  logic                 clk,
    input  logic                 reset,
    motor_sequenciador_if.slave  bus
);

    typedef enum logic [1:0] {
        PARADO      = 2'b00,
        PARTIDA     = 2'b01,
        FUNCIONANDO = 2'b10,
        DESLIGANDO  = 2'b11
    } estado_t;

    localparam logic [3:0] T_ADMISSAO   = 4'b1000;
    localparam logic [3:0] T_COMPRESSAO = 4'b0100;
    localparam logic [3:0] T_IGNICAO    = 4'b0010;
    localparam logic [3:0] T_EXAUSTAO   = 4'b0001;

    localparam int CW = (RAMPA_DIV > 1) ? $clog2(RAMPA_DIV) : 1;

    localparam logic [12:0] RPM_PARTIDA_W = 13'(RPM_PARTIDA);
    localparam logic [12:0] RPM_LIMITE_W  = 13'(RPM_LIMITE);
    localparam logic [12:0] RPM_MAX_W     = 13'(RPM_MAX);
    localparam logic [14:0] RPM_MAX_15    = 15'(RPM_MAX);
    localparam logic [14:0] LENTA_15      = 15'(RPM_MARCHA_LENTA);
    localparam logic [14:0] GANHO_15      = 15'(GANHO_ACEL);
    localparam logic [16:0] PASSO_17      = 17'(PASSO_FASE);
    localparam logic [CW-1:0] CNT_FIM     = CW'(RAMPA_DIV - 1);

    estado_t     estado_q, estado_d;
    logic        pronto_q, pronto_d;
    logic [3:0]  cil1_q, cil1_d;
    logic [3:0]  cil2_q, cil2_d;
    logic        ign1_q, ign1_d;
    logic        ign2_q, ign2_d;
    logic [12:0] rpm_q, rpm_d;
    logic [12:0] alvo_q, alvo_d;
    logic [15:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [14:0] alvo_acel;
    logic [16:0] soma;
    logic        rampa_passo;
    logic        avanca;
    logic        ign_ok;
    logic [3:0]  cil1_prox;
    logic [3:0]  cil2_prox;

    // Illegal codes restart the cycle at ADMISSAO.
    function automatic logic [3:0] prox_tempo(input logic [3:0] t);
        logic [3:0] r;
        case (t)
            T_ADMISSAO:   r = T_COMPRESSAO;
            T_COMPRESSAO: r = T_IGNICAO;
            T_IGNICAO:    r = T_EXAUSTAO;
            T_EXAUSTAO:   r = T_ADMISSAO;
            default:      r = T_ADMISSAO;
        endcase
        return r;
    endfunction

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            PARADO: begin
                if (bus.partida && !bus.desligar) estado_d = PARTIDA;
            end
            PARTIDA: begin
                if (bus.desligar)               estado_d = DESLIGANDO;
                else if (rpm_q == RPM_PARTIDA_W) estado_d = FUNCIONANDO;
            end
            FUNCIONANDO: begin
                if (bus.desligar) estado_d = DESLIGANDO;
            end
            DESLIGANDO: begin
                if (rpm_q == '0) estado_d = PARADO;
            end
        endcase
    end

    assign pronto_d = (estado_d == FUNCIONANDO);

    // Throttle target in 15 bits so 1000 + 255*28 cannot wrap before saturation.
    assign alvo_acel = LENTA_15 + 15'(bus.acelerador) * GANHO_15;

    always_comb begin
        alvo_d = '0;
        unique case (estado_q)
            PARADO:      alvo_d = '0;
            PARTIDA:     alvo_d = RPM_PARTIDA_W;
            FUNCIONANDO: alvo_d = (alvo_acel > RPM_MAX_15) ? RPM_MAX_W
                                                           : alvo_acel[12:0];
            DESLIGANDO:  alvo_d = '0;
        endcase
    end

    // Free-running divider; rpm only moves on its wrap.
    assign rampa_passo = (cnt_q == CNT_FIM);
    assign cnt_d = rampa_passo ? '0 : cnt_q + 1'b1;

    always_comb begin
        rpm_d = rpm_q;
        if (rampa_passo) begin
            if (rpm_q < alvo_q)      rpm_d = rpm_q + 13'd1;
            else if (rpm_q > alvo_q) rpm_d = rpm_q - 13'd1;
        end
    end

    // acc stays below PASSO_FASE and rpm < PASSO_FASE, so one
    // subtraction per cycle is always enough; rpm==0 never advances.
    assign soma   = {1'b0, acc_q} + 17'(rpm_q);
    assign avanca = (estado_q != PARADO) && (soma >= PASSO_17);

    always_comb begin
        if (estado_q == PARADO) acc_d = '0;
        else if (avanca)        acc_d = 16'(soma - PASSO_17);
        else                    acc_d = soma[15:0];
    end

    assign cil1_prox = prox_tempo(cil1_q);
    assign cil2_prox = prox_tempo(cil2_q);
    assign cil1_d    = avanca ? cil1_prox : cil1_q;
    assign cil2_d    = avanca ? cil2_prox : cil2_q;

    // Spark only while cranking/running and under the rev limit.
    assign ign_ok = ((estado_q == PARTIDA) || (estado_q == FUNCIONANDO))
                 && (rpm_q < RPM_LIMITE_W);
    assign ign1_d = avanca && ign_ok && (cil1_prox == T_IGNICAO);
    assign ign2_d = avanca && ign_ok && (cil2_prox == T_IGNICAO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= PARADO;
            pronto_q <= 1'b0;
            cil1_q   <= T_ADMISSAO;
            cil2_q   <= T_IGNICAO;
            ign1_q   <= 1'b0;
            ign2_q   <= 1'b0;
            rpm_q    <= '0;
            alvo_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            pronto_q <= pronto_d;
            cil1_q   <= cil1_d;
            cil2_q   <= cil2_d;
            ign1_q   <= ign1_d;
            ign2_q   <= ign2_d;
            rpm_q    <= rpm_d;
            alvo_q   <= alvo_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.estado_motor     = estado_q;
    assign bus.pronto           = pronto_q;
    assign bus.estado_cilindro1 = cil1_q;
    assign bus.estado_cilindro2 = cil2_q;
    assign bus.ignicao1         = ign1_q;
    assign bus.ignicao2         = ign2_q;
    assign bus.rpm              = rpm_q;
    assign bus.rpm_alvo         = alvo_q;

endmodule

// File: tb/tb_motor_sequenciador.sv
// Directed bench for motor_sequenciador (RAMPA_DIV=1).
// Covers reset, crank, idle timing, throttle, rev limiter, shutdown, restart.
module tb_motor_sequenciador;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    motor_sequenciador_if bus();

    motor_sequenciador #(.RAMPA_DIV(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int ncomp = 0;
    int nfail = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // sel 0: cyl1 changes, 1: ignicao1, 2: ignicao2, 3: rpm == val
    task automatic wait_ev(input string tag, input int sel, input int val,
                           input int budget, output int n);
        logic [3:0] c0;
        logic       hit;
        c0  = bus.estado_cilindro1;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < budget) begin
            tick(1);
            n++;
            case (sel)
                0:       hit = (bus.estado_cilindro1 != c0);
                1:       hit = bus.ignicao1;
                2:       hit = bus.ignicao2;
                default: hit = (32'(bus.rpm) == val);
            endcase
        end
        if (!hit) begin
            ncomp++;
            nfail++;
            $error("FAIL %s: observed timeout after %0d cycles expected event",
                   tag, budget);
        end
    endtask

    initial begin
        int n, n2, n3, n4, nign, adv, saiu;
        logic [3:0] prev;

        bus.partida    = 1'b0;
        bus.desligar   = 1'b0;
        bus.acelerador = 8'd0;
        tick(3);

        chk("rst_estado", 32'(bus.estado_motor), 0);
        chk("rst_cil1", 32'(bus.estado_cilindro1), 8);
        chk("rst_cil2", 32'(bus.estado_cilindro2), 2);
        chk("rst_rpm", 32'(bus.rpm), 0);
        chk("rst_alvo", 32'(bus.rpm_alvo), 0);
        chk("rst_ign1", 32'(bus.ignicao1), 0);
        chk("rst_ign2", 32'(bus.ignicao2), 0);
        chk("rst_pronto", 32'(bus.pronto), 0);

        reset = 1'b1;
        tick(5);
        chk("idle_estado", 32'(bus.estado_motor), 0);
        chk("idle_cil1", 32'(bus.estado_cilindro1), 8);
        chk("idle_cil2", 32'(bus.estado_cilindro2), 2);

        // crank
        bus.partida = 1'b1;
        tick(1);
        chk("crank_estado", 32'(bus.estado_motor), 1);
        chk("crank_pronto", 32'(bus.pronto), 0);
        bus.partida = 1'b0;
        tick(1);
        chk("crank_alvo", 32'(bus.rpm_alvo), 800);
        chk("crank_rpm0", 32'(bus.rpm), 0);
        tick(1);
        chk("crank_rpm1", 32'(bus.rpm), 1);
        wait_ev("crank_ramp", 3, 800, 2000, n);
        chk("crank_ramp_len", 32'(n), 799);
        chk("crank_still", 32'(bus.estado_motor), 1);
        tick(1);
        chk("run_estado", 32'(bus.estado_motor), 2);
        chk("run_pronto", 32'(bus.pronto), 1);
        chk("run_alvo_lat", 32'(bus.rpm_alvo), 800);

        // idle target 1000, ramp 800->1000
        wait_ev("idle_ramp", 3, 1000, 1000, n);
        chk("idle_ramp_len", 32'(n), 201);
        chk("idle_alvo", 32'(bus.rpm_alvo), 1000);

        // timing at 1000 rpm
        wait_ev("ign1_a", 1, 0, 200, n);
        wait_ev("ign2_a", 2, 0, 200, n2);
        chk("ign_offset", 32'(n2), 40);
        wait_ev("ign1_b", 1, 0, 200, n3);
        chk("ign1_period", 32'(n2 + n3), 80);
        wait_ev("ign2_b", 2, 0, 200, n4);
        chk("ign2_period", 32'(n3 + n4), 80);
        tick(1);
        chk("ign2_width", 32'(bus.ignicao2), 0);
        wait_ev("stroke_a", 0, 0, 100, n);
        wait_ev("stroke_b", 0, 0, 100, n);
        chk("stroke_period", 32'(n), 20);

        // throttle
        bus.acelerador = 8'd100;
        tick(1);
        chk("alvo_100", 32'(bus.rpm_alvo), 3800);
        bus.acelerador = 8'd255;
        tick(1);
        chk("alvo_sat", 32'(bus.rpm_alvo), 8000);

        // rev limiter
        n = 0;
        nign = 0;
        while (bus.rpm != 13'd8000 && n < 8000) begin
            tick(1);
            n++;
            if (bus.rpm > 13'd7800 && (bus.ignicao1 || bus.ignicao2)) nign++;
        end
        chk("rpm_top", 32'(bus.rpm), 8000);
        adv = 0;
        for (int i = 0; i < 400; i++) begin
            prev = bus.estado_cilindro1;
            tick(1);
            if (bus.estado_cilindro1 != prev) adv++;
            if (bus.ignicao1 || bus.ignicao2) nign++;
        end
        chk("limiter_ign", 32'(nign), 0);
        chk("limiter_adv", 32'(adv), 160);
        chk("rpm_hold", 32'(bus.rpm), 8000);

        // shutdown, desligar wins over partida
        bus.partida  = 1'b1;
        bus.desligar = 1'b1;
        tick(1);
        chk("off_estado", 32'(bus.estado_motor), 3);
        chk("off_pronto", 32'(bus.pronto), 0);
        tick(1);
        chk("off_alvo", 32'(bus.rpm_alvo), 0);
        bus.desligar = 1'b0;
        nign = 0;
        saiu = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus.ignicao1 || bus.ignicao2) nign++;
            if (bus.estado_motor != 2'b11) saiu++;
        end
        bus.partida = 1'b0;
        n = 0;
        while (bus.rpm != 13'd0 && n < 9000) begin
            tick(1);
            n++;
            if (bus.ignicao1 || bus.ignicao2) nign++;
            if (bus.estado_motor != 2'b11) saiu++;
        end
        chk("off_rpm0", 32'(bus.rpm), 0);
        chk("off_ign", 32'(nign), 0);
        chk("off_stay", 32'(saiu), 0);
        chk("off_at0", 32'(bus.estado_motor), 3);
        tick(1);
        chk("stop_estado", 32'(bus.estado_motor), 0);
        chk("stop_pronto", 32'(bus.pronto), 0);

        // restart: accumulator starts from zero
        bus.partida = 1'b1;
        tick(1);
        chk("re_estado", 32'(bus.estado_motor), 1);
        bus.partida = 1'b0;
        wait_ev("re_first_adv", 0, 0, 400, n);
        chk("re_first_adv", 32'(n), 202);

        // async reset mid-run
        bus.acelerador = 8'd72;
        wait_ev("to_3000", 3, 3000, 5000, n);
        #2 reset = 1'b0;
        #1;
        chk("ar_estado", 32'(bus.estado_motor), 0);
        chk("ar_cil1", 32'(bus.estado_cilindro1), 8);
        chk("ar_cil2", 32'(bus.estado_cilindro2), 2);
        chk("ar_rpm", 32'(bus.rpm), 0);
        chk("ar_alvo", 32'(bus.rpm_alvo), 0);
        chk("ar_ign", 32'({bus.ignicao1, bus.ignicao2}), 0);
        chk("ar_pronto", 32'(bus.pronto), 0);
        tick(1);
        reset = 1'b1;
        tick(10);
        chk("post_estado", 32'(bus.estado_motor), 0);
        chk("post_cil1", 32'(bus.estado_cilindro1), 8);
        chk("post_cil2", 32'(bus.estado_cilindro2), 2);
        chk("post_rpm", 32'(bus.rpm), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
